// File: rtl/note_sequencer.sv
// Note sequencer: takes note events and holds TONE/VOL for each note's length in ticks, silencing a trailing gap.
// Latency: TONE/VOL change one cycle after the accepting edge; every note takes LEN*TICK_DIV cycles plus one cycle in WAIT.
// Backpressure: NOTE_READY is high only in WAIT, so a note is accepted only between notes; STOP wins over any offered note.
module note_sequencer #(
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       NOTE_VALID,
  output logic       NOTE_READY,
  input  logic [5:0] NOTE_TONE,
  input  logic [3:0] NOTE_VOL,
  input  logic [7:0] NOTE_LEN,
  output logic [5:0] TONE,
  output logic [3:0] VOL,
  output logic       BUSY,
  output logic       DONE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [7:0]    remaining;
  logic          gap_ok;   // note is longer than the gap, so its tail gets silenced

  logic          tick;
  logic [7:0]    rem_dec;

  // Tick on the last prescaler count; remaining is never zero while a note is timed.
  always_comb begin
    tick    = (presc == PW'(TICK_DIV - 1));
    rem_dec = remaining - 8'd1;
  end

  // Ready and busy follow the state directly.
  always_comb begin
    NOTE_READY = (state == S_WAIT);
    BUSY       = (state != S_IDLE);
  end

  // Main sequencer: state, prescaler, note timing and registered tone outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      presc     <= '0;
      remaining <= '0;
      gap_ok    <= 1'b0;
      TONE      <= '0;
      VOL       <= '0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (STOP) begin
        state <= S_IDLE;
        presc <= '0;
        TONE  <= '0;
        VOL   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            presc <= '0;
            if (START) state <= S_WAIT;
          end
          S_WAIT: begin
            presc <= '0;
            if (NOTE_VALID) begin
              if (NOTE_LEN != 8'd0) begin
                TONE      <= NOTE_TONE;
                VOL       <= NOTE_VOL;
                remaining <= NOTE_LEN;
                gap_ok    <= ({1'b0, NOTE_LEN} > 9'(GAP_TICKS));
                state     <= S_PLAY;
              end else begin
                // End-of-song marker.
                DONE  <= 1'b1;
                state <= S_IDLE;
              end
            end
          end
          S_PLAY: begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              remaining <= rem_dec;
              if (rem_dec == 8'd0) begin
                state <= S_WAIT;
                TONE  <= '0;
                VOL   <= '0;
              end else if (gap_ok && (rem_dec == 8'(GAP_TICKS))) begin
                state <= S_GAP;
                TONE  <= '0;
                VOL   <= '0;
              end
            end
          end
          default: begin  // S_GAP: already silent, just run out the remaining ticks
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              remaining <= rem_dec;
              if (rem_dec == 8'd0) state <= S_WAIT;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: three instances (GAP_TICKS 0/1/2, TICK_DIV 4) share one stimulus.
// Total note duration is independent of the gap, so READY/BUSY/DONE stay aligned across instances.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_note_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START, STOP, NOTE_VALID;
  logic [5:0] NOTE_TONE;
  logic [3:0] NOTE_VOL;
  logic [7:0] NOTE_LEN;

  logic [5:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2;
  logic       rdy0, rdy1, rdy2, busy0, busy1, busy2, done0, done1, done2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  note_sequencer #(.TICK_DIV(4), .GAP_TICKS(0)) u0 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .NOTE_VALID(NOTE_VALID), .NOTE_READY(rdy0),
    .NOTE_TONE(NOTE_TONE), .NOTE_VOL(NOTE_VOL), .NOTE_LEN(NOTE_LEN),
    .TONE(tone0), .VOL(vol0), .BUSY(busy0), .DONE(done0));

  note_sequencer #(.TICK_DIV(4), .GAP_TICKS(1)) u1 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .NOTE_VALID(NOTE_VALID), .NOTE_READY(rdy1),
    .NOTE_TONE(NOTE_TONE), .NOTE_VOL(NOTE_VOL), .NOTE_LEN(NOTE_LEN),
    .TONE(tone1), .VOL(vol1), .BUSY(busy1), .DONE(done1));

  note_sequencer #(.TICK_DIV(4), .GAP_TICKS(2)) u2 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .NOTE_VALID(NOTE_VALID), .NOTE_READY(rdy2),
    .NOTE_TONE(NOTE_TONE), .NOTE_VOL(NOTE_VOL), .NOTE_LEN(NOTE_LEN),
    .TONE(tone2), .VOL(vol2), .BUSY(busy2), .DONE(done2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic note(input logic [5:0] t, input logic [3:0] v, input logic [7:0] l);
    NOTE_TONE = t;
    NOTE_VOL  = v;
    NOTE_LEN  = l;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; STOP = 1'b0; NOTE_VALID = 1'b0;
    note(6'd0, 4'd0, 8'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("rst_tone", 32'(tone1), 0);
    chk("rst_vol",  32'(vol1),  0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_rdy",  32'(rdy1),  0);
    chk("rst_done", 32'(done1), 0);

    // Single note {12,8,3}; the accepting edge is edge 0, cycle k follows edge k-1.
    START = 1'b1;
    step();
    chk("wait_rdy",  32'(rdy1),  1);
    chk("wait_busy", 32'(busy1), 1);
    chk("wait_tone", 32'(tone1), 0);
    START = 1'b0; NOTE_VALID = 1'b1; note(6'd12, 4'd8, 8'd3);
    step();
    NOTE_VALID = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("n1_tone_g1_c%0d", k), 32'(tone1), (k <= 8) ? 12 : 0);
      chk($sformatf("n1_vol_g1_c%0d", k),  32'(vol1),  (k <= 8) ? 8 : 0);
      chk($sformatf("n1_tone_g2_c%0d", k), 32'(tone2), (k <= 4) ? 12 : 0);
      chk($sformatf("n1_tone_g0_c%0d", k), 32'(tone0), (k <= 12) ? 12 : 0);
      chk($sformatf("n1_rdy_c%0d", k),     32'(rdy1),  32'(k == 13));
      if (k < 13) step();
    end

    // LEN=1 with GAP_TICKS=1: no gap, sounds the full 4 cycles.
    NOTE_VALID = 1'b1; note(6'd5, 4'd3, 8'd1);
    step();
    NOTE_VALID = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("len1_tone_g1_c%0d", k), 32'(tone1), (k <= 4) ? 5 : 0);
      chk($sformatf("len1_rdy_c%0d", k),     32'(rdy1),  32'(k == 5));
      if (k < 5) step();
    end

    // LEN=2 with GAP_TICKS=2: no gap, sounds 8 cycles; GAP_TICKS=1 instance gaps after 4.
    NOTE_VALID = 1'b1; note(6'd7, 4'd9, 8'd2);
    step();
    NOTE_VALID = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("len2_tone_g2_c%0d", k), 32'(tone2), (k <= 8) ? 7 : 0);
      chk($sformatf("len2_vol_g2_c%0d", k),  32'(vol2),  (k <= 8) ? 9 : 0);
      chk($sformatf("len2_tone_g1_c%0d", k), 32'(tone1), (k <= 4) ? 7 : 0);
      chk($sformatf("len2_rdy_c%0d", k),     32'(rdy2),  32'(k == 9));
      if (k < 9) step();
    end

    // Back-to-back with VALID held: LEN=2, LEN=1, then end marker.
    NOTE_VALID = 1'b1; note(6'd20, 4'd4, 8'd2);
    step();
    note(6'd21, 4'd5, 8'd1);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("b2b_tone_g0_c%0d", k), 32'(tone0),
          (k <= 8) ? 20 : ((k >= 10 && k <= 13) ? 21 : 0));
      chk($sformatf("b2b_tone_g1_c%0d", k), 32'(tone1),
          (k <= 4) ? 20 : ((k >= 10 && k <= 13) ? 21 : 0));
      chk($sformatf("b2b_rdy_c%0d", k),  32'(rdy0),  32'(k == 9 || k == 14));
      chk($sformatf("b2b_done_c%0d", k), 32'(done0), 32'(k == 15));
      chk($sformatf("b2b_busy_c%0d", k), 32'(busy0), 32'(k <= 14));
      if (k == 10) note(6'd0, 4'd0, 8'd0);
      if (k == 15) NOTE_VALID = 1'b0;
      if (k < 16) step();
    end

    // STOP during PLAY with START and VALID asserted.
    START = 1'b1;
    step();
    START = 1'b0; NOTE_VALID = 1'b1; note(6'd9, 4'd6, 8'd5);
    step();
    note(6'd33, 4'd2, 8'd7);
    step();
    step();
    chk("stop_pre_tone", 32'(tone1), 9);
    STOP = 1'b1; START = 1'b1;
    step();
    chk("stop_tone", 32'(tone1), 0);
    chk("stop_vol",  32'(vol1),  0);
    chk("stop_busy", 32'(busy1), 0);
    chk("stop_rdy",  32'(rdy1),  0);
    chk("stop_done", 32'(done1), 0);
    step();
    chk("stop_hold_rdy",  32'(rdy1),  0);
    chk("stop_hold_busy", 32'(busy1), 0);
    STOP = 1'b0; START = 1'b0; NOTE_VALID = 1'b0;

    // STOP beats a transfer offered in WAIT.
    START = 1'b1;
    step();
    chk("stopw_pre_rdy", 32'(rdy1), 1);
    START = 1'b0; NOTE_VALID = 1'b1; STOP = 1'b1;
    step();
    chk("stopw_tone", 32'(tone1), 0);
    chk("stopw_busy", 32'(busy1), 0);
    chk("stopw_rdy",  32'(rdy1),  0);
    chk("stopw_done", 32'(done1), 0);
    STOP = 1'b0; NOTE_VALID = 1'b0;
    step();
    chk("stopw_idle_busy", 32'(busy1), 0);

    // Asynchronous reset in the middle of a note.
    START = 1'b1;
    step();
    START = 1'b0; NOTE_VALID = 1'b1; note(6'd40, 4'd7, 8'd10);
    step();
    NOTE_VALID = 1'b0;
    step();
    step();
    chk("arst_pre_tone", 32'(tone1), 40);
    RST = 1'b1;
    #1;
    chk("arst_tone", 32'(tone1), 0);
    chk("arst_vol",  32'(vol1),  0);
    chk("arst_busy", 32'(busy1), 0);
    chk("arst_rdy",  32'(rdy1),  0);
    chk("arst_done", 32'(done1), 0);
    step();
    RST = 1'b0;
    step();
    step();
    chk("arst_need_start", 32'(busy1), 0);
    chk("arst_no_done",    32'(done1), 0);

    // Full-length note: 255 ticks, no wrap of remaining.
    START = 1'b1;
    step();
    START = 1'b0; NOTE_VALID = 1'b1; note(6'd63, 4'd15, 8'd255);
    step();
    NOTE_VALID = 1'b0;
    for (int k = 1; k <= 1021; k++) begin
      if (k == 1) begin
        chk("full_tone_c1", 32'(tone1), 63);
        chk("full_vol_c1",  32'(vol1),  15);
      end
      if (k == 1012) chk("full_g2_c1012", 32'(tone2), 63);
      if (k == 1013) chk("full_g2_c1013", 32'(tone2), 0);
      if (k == 1016) chk("full_g1_c1016", 32'(tone1), 63);
      if (k == 1017) begin
        chk("full_g1_c1017",     32'(tone1), 0);
        chk("full_g1_vol_c1017", 32'(vol1),  0);
      end
      if (k == 1020) begin
        chk("full_rdy_c1020",  32'(rdy1),  0);
        chk("full_busy_c1020", 32'(busy1), 1);
        chk("full_g0_c1020",   32'(tone0), 63);
      end
      if (k == 1021) begin
        chk("full_rdy_c1021", 32'(rdy1),  1);
        chk("full_g0_c1021",  32'(tone0), 0);
        chk("full_g1_c1021",  32'(tone1), 0);
      end
      if (k < 1021) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
